// File: rtl/res_hex_uart.sv
// res_hex_uart: response-stream debug sink. Bytes are queued in a FIFO,
// rendered as two uppercase hex digits plus a space (or CR LF at the end of
// a text line) and shifted out on an 8N1 UART line with no idle gaps.
module res_hex_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4,
    parameter int LINE_BYTES   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               in_stb_i,
    input  logic [7:0]         in_data_i,
    output logic               in_ack_o,
    output logic               txd_o,
    output logic               busy_o,
    output logic [FIFO_AW:0]   fifo_level_o
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int LW    = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_SEP, S_CR, S_LF} state_t;

    // FIFO
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic               push, pop, fifo_empty;
    logic [7:0]         head;

    // formatter
    state_t             state_q;
    logic [7:0]         byte_q;
    logic [LW-1:0]      line_q;
    logic               sent_q;
    logic               line_end;

    // transmitter
    logic               tx_act_q, txd_q;
    logic [3:0]         bit_q;
    logic [CW-1:0]      cnt_q;
    logic [7:0]         sh_q;
    logic               tx_last, tx_free, tx_start;
    logic [7:0]         tx_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] state_char(input state_t s, input logic [7:0] b);
        case (s)
            S_HI:    return hex_char(b[7:4]);
            S_LO:    return hex_char(b[3:0]);
            S_SEP:   return 8'h20;
            S_CR:    return 8'h0D;
            S_LF:    return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // Full test uses the registered level only, so a same-cycle pop never frees a slot.
    assign in_ack_o     = rst_n_i & in_stb_i & (level_q != (FIFO_AW+1)'(DEPTH));
    assign push         = in_ack_o;
    assign fifo_empty   = (level_q == '0);
    assign head         = mem_q[rd_ptr_q];
    assign line_end     = (line_q == LW'(LINE_BYTES - 1));
    assign tx_last      = tx_act_q && (bit_q == 4'd9) && (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign tx_free      = !tx_act_q || tx_last;
    assign txd_o        = txd_q;
    assign fifo_level_o = level_q;
    assign busy_o       = !fifo_empty || (state_q != S_IDLE) || tx_act_q;

    // Hand-off decode: the next char is loaded on the very edge the current stop bit ends.
    always_comb begin
        pop      = 1'b0;
        tx_start = 1'b0;
        tx_char  = 8'h00;
        if (state_q == S_IDLE) begin
            pop = !fifo_empty;
        end else if (!sent_q) begin
            tx_start = tx_free;
            tx_char  = state_char(state_q, byte_q);
        end else if (tx_last) begin
            case (state_q)
                S_HI: begin
                    tx_start = 1'b1;
                    tx_char  = state_char(S_LO, byte_q);
                end
                S_LO: begin
                    tx_start = 1'b1;
                    tx_char  = line_end ? state_char(S_CR, byte_q) : state_char(S_SEP, byte_q);
                end
                S_CR: begin
                    tx_start = 1'b1;
                    tx_char  = state_char(S_LF, byte_q);
                end
                default: begin
                    // separator or LF finished: chain straight into the next byte if one waits
                    pop      = !fifo_empty;
                    tx_start = !fifo_empty;
                    tx_char  = hex_char(head[7:4]);
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Formatter FSM: walks HI, LO, then SEP or CR/LF, advancing as each char is handed off.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            line_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                if (pop) begin
                    byte_q  <= head;
                    state_q <= S_HI;
                    sent_q  <= 1'b0;
                end
            end else if (!sent_q) begin
                if (tx_start) sent_q <= 1'b1;
            end else if (tx_last) begin
                case (state_q)
                    S_HI: state_q <= S_LO;
                    S_LO: begin
                        if (line_end) begin
                            state_q <= S_CR;
                            line_q  <= '0;
                        end else begin
                            state_q <= S_SEP;
                            line_q  <= line_q + 1'b1;
                        end
                    end
                    S_CR: state_q <= S_LF;
                    default: begin
                        if (pop) begin
                            byte_q  <= head;
                            state_q <= S_HI;
                        end else begin
                            state_q <= S_IDLE;
                            sent_q  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // 8N1 shifter: start bit, D0..D7 LSB first, stop bit, each CLKS_PER_BIT cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_act_q <= 1'b0;
            txd_q    <= 1'b1;
            bit_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
        end else if (tx_start) begin
            tx_act_q <= 1'b1;
            txd_q    <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= tx_char;
        end else if (tx_act_q) begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_q <= '0;
                if (bit_q == 4'd9) begin
                    tx_act_q <= 1'b0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        txd_q <= sh_q[0];
                        sh_q  <= {1'b0, sh_q[7:1]};
                    end else begin
                        txd_q <= 1'b1;
                    end
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_res_hex_uart.sv
// Bench for res_hex_uart: directed steps feed bytes; a UART receiver decodes
// TXD and compares each char against a scoreboard queue filled at accept time.
module tb_res_hex_uart;
    localparam int CPB = 4;
    localparam int AW  = 2;
    localparam int LB  = 2;
    localparam int FRAME = 10 * CPB;

    logic          clk;
    logic          rst_n;
    logic          in_stb;
    logic [7:0]    in_data;
    logic          in_ack;
    logic          txd;
    logic          busy;
    logic [AW:0]   fifo_level;

    int            total;
    int            bad;
    int            cyc;
    int            mline;
    int            model_n;
    logic [7:0]    exp_q[$];
    int            start_q[$];
    logic [7:0]    b5 [6];

    res_hex_uart #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .LINE_BYTES(LB)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .in_stb_i     (in_stb),
        .in_data_i    (in_data),
        .in_ack_o     (in_ack),
        .txd_o        (txd),
        .busy_o       (busy),
        .fifo_level_o (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        logic [127:0] t;
        t = "0123456789ABCDEF";
        return t[8*(15 - int'(n)) +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        exp_q.push_back(hexc(b[7:4]));
        exp_q.push_back(hexc(b[3:0]));
        if (mline == LB - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            mline = 0;
            model_n += 4;
        end else begin
            exp_q.push_back(8'h20);
            mline++;
            model_n += 3;
        end
    endtask

    // Receiver: samples every negedge, so each bit must hold for all CPB samples.
    task automatic uart_mon();
        logic [7:0] d;
        logic [7:0] e;
        logic       cur, ok, aborted;
        int         s;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || txd !== 1'b0) continue;
            s = cyc; ok = 1'b1; aborted = 1'b0; cur = 1'b0; d = '0;
            for (int i = 1; i < 40; i++) begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                if (i % 4 == 0) begin
                    cur = txd;
                    if (i < 36) d[i/4 - 1] = txd;
                end else if (txd !== cur) begin
                    ok = 1'b0;
                end
                if (i >= 36 && txd !== 1'b1) ok = 1'b0;
            end
            if (aborted) continue;
            start_q.push_back(s);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 8'hxx;
            total++;
            assert (d === e && ok === 1'b1) else begin
                bad++;
                $error("FAIL rx_char got=%h want=%h framing_ok=%0d", d, e, ok);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int t_acc);
        int n = 0;
        in_stb = 1'b1;
        in_data = b;
        #1;
        while (in_ack !== 1'b1 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        t_acc = cyc + 1;
        chk("ack_wait", 32'(in_ack), 32'd1);
        if (in_ack === 1'b1) model_push(b);
        @(negedge clk);
        in_stb = 1'b0;
    endtask

    task automatic wait_idle(output int drop);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        drop = cyc;
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_stb = 1'b0;
        exp_q.delete();
        mline = 0;
        model_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_q.delete();
    endtask

    task automatic check_test(input string tag);
        int gaps = 0;
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_frames"}, 32'(start_q.size()), 32'(model_n));
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != FRAME) gaps++;
        chk({tag, "_gaps"}, 32'(gaps), 32'd0);
    endtask

    initial begin
        int t, t0, idx, n, maxlvl, badseq, drop;
        int acc [6];
        b5 = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
        total = 0; bad = 0; mline = 0; model_n = 0;
        rst_n = 1'b0;
        in_stb = 1'b1;
        in_data = 8'h55;
        fork
            uart_mon();
        join_none

        // 1: reset holds everything quiet even with a pending strobe
        repeat (4) @(negedge clk);
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ack", 32'(in_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ack", 32'(in_ack), 32'd1);
        if (in_ack === 1'b1) model_push(8'h55);
        @(negedge clk);
        in_stb = 1'b0;
        chk("t1_level", 32'(fifo_level), 32'd1);
        wait_idle(drop);
        check_test("t1");

        // 2: single byte latency, bit timing and busy window
        do_reset();
        send_byte(8'h41, t);
        chk("t2_busy", 32'(busy), 32'd1);
        wait_idle(drop);
        chk("t2_start", (start_q.size() > 0) ? 32'(start_q[0]) : 32'hFFFF_FFFF, 32'(t + 2));
        chk("t2_busy_drop", 32'(drop), 32'(t + 2 + 3 * FRAME));
        check_test("t2");

        // 3: hex digit boundaries
        do_reset();
        send_byte(8'h00, t);
        send_byte(8'h9A, t);
        send_byte(8'hFF, t);
        wait_idle(drop);
        check_test("t3");

        // 4: line counter wrap inserts CR LF
        do_reset();
        send_byte(8'h01, t);
        send_byte(8'h02, t);
        send_byte(8'h03, t);
        wait_idle(drop);
        check_test("t4");

        // 5: held strobe fills the FIFO and then sees back-pressure
        do_reset();
        idx = 0; n = 0; maxlvl = 0;
        in_stb = 1'b1;
        in_data = b5[0];
        while (idx < 6 && n < 3000) begin
            #1;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (in_ack === 1'b1) begin
                acc[idx] = cyc + 1;
                model_push(b5[idx]);
                idx++;
            end
            @(negedge clk);
            if (idx < 6) in_data = b5[idx];
            else in_stb = 1'b0;
            n++;
        end
        in_stb = 1'b0;
        chk("t5_acks", 32'(idx), 32'd6);
        badseq = 0;
        for (int k = 1; k < 5; k++)
            if (acc[k] != acc[0] + k) badseq++;
        chk("t5_consec", 32'(badseq), 32'd0);
        chk("t5_maxlvl", 32'(maxlvl), 32'd4);
        chk("t5_sixth_late", 32'(acc[5] >= acc[0] + 2 + 3 * FRAME), 32'd1);
        wait_idle(drop);
        check_test("t5");

        // 6: asynchronous reset in the middle of a data bit
        do_reset();
        send_byte(8'h12, t0);
        send_byte(8'h34, t);
        send_byte(8'h56, t);
        // second byte's high digit '3' starts at t0+122; D2 (a zero) spans t0+134..t0+137
        while (cyc < t0 + 2 + 3 * FRAME + 13) @(negedge clk);
        chk("t6_pre_txd", 32'(txd), 32'd0);
        chk("t6_pre_level", 32'(fifo_level), 32'd1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        mline = 0;
        model_n = 0;
        #1;
        chk("t6_txd", 32'(txd), 32'd1);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_q.delete();
        send_byte(8'h5C, t);
        wait_idle(drop);
        check_test("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
